snake_pio_write_arbiter: RTL and testbench
==========================================

# snake_pio_write_arbiter

Round-robin write arbiter sharing one memory-mapped 31-bit PIO output slave (the snake x/y coordinate output ports) between several on-chip requesters, such as the game-logic engine, the reset/respawn sequencer and a debug injector. It sits between the requesters and the slave's `address`/`chipselect`/`write_n`/`writedata` port. Each write is a registered, single-cycle bus strobe, followed by a programmable idle gap so the downstream display logic can latch every coordinate.

## Interface
- `NUM_REQ`, default 4: number of requesters, 2..8.
- `DATA_W`, default 31: PIO data width. Bus `writedata` is always 32 bits.
- `ADDR_W`, default 2: PIO register address width.
- `GAP_CYCLES`, default 2: idle cycles inserted after each write strobe, 0..15.

Ports:
- `clk`, in, 1: the single clock; all logic is on the rising edge.
- `reset`, in, 1: asynchronous, active-high reset.
- `req`, in, NUM_REQ: per-requester write request, level-sensitive.
- `req_addr`, in, NUM_REQ*ADDR_W: requester i occupies bits [i*ADDR_W +: ADDR_W].
- `req_data`, in, NUM_REQ*DATA_W: requester i occupies bits [i*DATA_W +: DATA_W].
- `gnt`, out, NUM_REQ: one-hot, one-cycle pulse. It is high in the same cycle as the winner's bus strobe.
- `busy`, out, 1: high whenever the state is not IDLE.
- `address`, out, ADDR_W: PIO address.
- `chipselect`, out, 1: PIO select.
- `write_n`, out, 1: PIO write strobe, active low.
- `writedata`, out, 32: {(32-DATA_W)'b0, data}.

## Operation
- All outputs are registered.
- Reset values:
  - `chipselect`=0, `write_n`=1, `address`=0, `writedata`=0
  - `gnt`=0, `busy`=0
  - state IDLE, gap counter 0
  - round-robin pointer `last`=NUM_REQ-1, so requester 0 has first priority.
- States:
  - IDLE: if `req` is nonzero, pick the winner by round-robin and go to WRITE. The winner is the first asserted index scanning `last`+1, `last`+2, … modulo NUM_REQ. In the same cycle, latch the winner's address and data, and update `last` to the winner. If `req` is zero, stay in IDLE.
  - WRITE (one cycle): `chipselect`=1, `write_n`=0, `gnt[winner]`=1. Next state is GAP if GAP_CYCLES>0, otherwise IDLE.
  - GAP: `chipselect`=0, `write_n`=1. Count GAP_CYCLES cycles, then go to IDLE.
- Address and data are captured at selection. A requester dropping `req` or changing data after selection does not affect the write in flight.
- A requester that holds `req` high after `gnt` is making a new request. It is re-arbitrated fairly and gets no back-to-back service while others are waiting.
- Requests arriving during WRITE or GAP wait; nothing is lost, because `req` is a level.
- Only the winner sees `gnt`. Losers keep `req` asserted.
- `address`, `writedata` and `gnt` return to 0 outside WRITE.

## Timing
- Selection latency: `req` first seen high in IDLE at edge T. The bus strobe and `gnt` appear in cycle T+1, lasting exactly one cycle.
- Throughput: one write every 2+GAP_CYCLES cycles under continuous requests. With GAP_CYCLES=0 that is one write every 2 cycles, because IDLE always takes one cycle.
- `busy` rises the cycle after selection, together with WRITE. It falls in the cycle IDLE is re-entered.
- If `req` rises in the same cycle as the GAP→IDLE transition, it is sampled in IDLE on the next edge.
- Reset asserted mid-WRITE or mid-GAP: the next cycle shows reset values, the in-flight write is abandoned, and `last` is restored to NUM_REQ-1.
- Reset asserted with `req` high: no strobe appears until one cycle after reset deasserts.

## Structure
- Package `snake_pio_pkg` holds:
  - state enum {IDLE, WRITE, GAP}
  - constants `PIO_DATA_W`=31, `PIO_ADDR_W`=2, `BUS_DATA_W`=32.
- Sub-module `snake_rr_picker`: purely combinational round-robin selector. Inputs are `req` and `last`; outputs are a one-hot winner and its index. It is instantiated once.
- The top level holds the FSM, gap counter, capture registers and output registers.

## Test plan
- Single request, GAP=2: req[1]=1 with addr=0 and data=31'h0000_0123, held for one cycle. Required: exactly one cycle of cs=1, write_n=0, address=0, writedata=32'h0000_0123 and gnt=4'b0010. Then 2 idle cycles, then `busy`=0.
- All 4 requesters held high from reset release. Required: strobe order 0,1,2,3,0, with strobes 4 cycles apart and gnt one-hot matching the strobe each time.
- Fairness: requester 2 is served first; then req[1] and req[3] are both high. Required: 3 is served before 1.
- GAP_CYCLES=0, req[0] held high continuously. Required: strobes every 2 cycles, and `write_n` never low in two consecutive cycles.
- Data masking: req_data=31'h7FFF_FFFF. Required: writedata=32'h7FFF_FFFF with bit 31 = 0.
- Reset mid-operation: assert reset during WRITE. Required: the next cycle shows cs=0, write_n=1, gnt=0, busy=0. After release with req[3] and req[0] high, requester 0 is served first.

Source files
------------

// File: rtl/snake_pio_pkg.sv
// Shared types and constants for the snake PIO write arbiter.
// The FSM states and default bus widths live here so the top level
// and the round-robin picker agree on them.
package snake_pio_pkg;

  // Arbiter FSM states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    GAP   = 2'd2
  } pio_state_e;

  // Default widths of the coordinate PIO slave
  localparam int PIO_DATA_W = 31;
  localparam int PIO_ADDR_W = 2;
  localparam int BUS_DATA_W = 32;

  // Width of a requester index for a given requester count (at least 1 bit)
  function automatic int req_idx_w(input int num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

endpackage : snake_pio_pkg

// File: rtl/snake_rr_picker.sv
// Combinational round-robin selector.
// Scans last+1, last+2, ... modulo NUM_REQ and returns the first asserted
// request as a one-hot vector plus its index. win_valid is low when no
// request is asserted; the other outputs are zero in that case.
module snake_rr_picker
  import snake_pio_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = req_idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last,
  output logic [NUM_REQ-1:0] win_onehot,
  output logic [IDX_W-1:0]   win_idx,
  output logic               win_valid
);

  int unsigned        cand_s;
  logic [IDX_W-1:0]   cand_idx_s;

  // Rotating priority scan starting just after the previous winner
  always_comb begin
    win_onehot = '0;
    win_idx    = '0;
    win_valid  = 1'b0;
    cand_s     = 32'd0;
    cand_idx_s = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand_s     = (32'(last) + 32'(k)) % 32'(NUM_REQ);
      cand_idx_s = IDX_W'(cand_s);
      if (!win_valid && req[cand_idx_s]) begin
        win_valid              = 1'b1;
        win_idx                = cand_idx_s;
        win_onehot[cand_idx_s] = 1'b1;
      end else begin
        win_valid = win_valid;
      end
    end
  end

endmodule : snake_rr_picker

// File: rtl/snake_pio_write_arbiter.sv
// Round-robin write arbiter in front of the snake coordinate PIO slave.
// Each granted write is a single registered bus strobe followed by
// GAP_CYCLES idle cycles so the display side can latch every coordinate.
// Address and data are taken at selection time straight into the bus
// output registers, which therefore double as the capture registers:
// later changes on req_addr/req_data cannot disturb a write in flight.
module snake_pio_write_arbiter
  import snake_pio_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_W     = PIO_DATA_W,
  parameter int ADDR_W     = PIO_ADDR_W,
  parameter int GAP_CYCLES = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        gnt,
  output logic                      busy,
  output logic [ADDR_W-1:0]         address,
  output logic                      chipselect,
  output logic                      write_n,
  output logic [BUS_DATA_W-1:0]     writedata
);

  localparam int         IDX_W    = req_idx_w(NUM_REQ);
  localparam logic [3:0] GAP_LAST = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;
  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_REQ - 1);

  pio_state_e           state_r;
  pio_state_e           state_nxt_s;
  logic [3:0]           gap_cnt_r;
  logic [3:0]           gap_cnt_nxt_s;
  logic [IDX_W-1:0]     last_r;

  logic [NUM_REQ-1:0]   pick_onehot_s;
  logic [IDX_W-1:0]     pick_idx_s;
  logic                 pick_valid_s;
  logic [ADDR_W-1:0]    sel_addr_s;
  logic [DATA_W-1:0]    sel_data_s;

  logic                 cs_nxt_s;
  logic                 wn_nxt_s;
  logic [ADDR_W-1:0]    addr_nxt_s;
  logic [BUS_DATA_W-1:0] wdata_nxt_s;
  logic [NUM_REQ-1:0]   gnt_nxt_s;
  logic                 busy_nxt_s;

  snake_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .req        (req),
    .last       (last_r),
    .win_onehot (pick_onehot_s),
    .win_idx    (pick_idx_s),
    .win_valid  (pick_valid_s)
  );

  // Winner's address and data slices from the packed request buses
  always_comb begin
    sel_addr_s = req_addr[pick_idx_s*ADDR_W +: ADDR_W];
    sel_data_s = req_data[pick_idx_s*DATA_W +: DATA_W];
  end

  // State, gap counter and round-robin pointer registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= IDLE;
      gap_cnt_r <= 4'd0;
      last_r    <= LAST_RST;
    end else begin
      state_r   <= state_nxt_s;
      gap_cnt_r <= gap_cnt_nxt_s;
      if (state_r == IDLE && pick_valid_s) begin
        last_r <= pick_idx_s;
      end
    end
  end

  // Next-state and gap counter sequencing
  always_comb begin
    state_nxt_s   = state_r;
    gap_cnt_nxt_s = gap_cnt_r;
    case (state_r)
      IDLE: begin
        gap_cnt_nxt_s = 4'd0;
        if (pick_valid_s) begin
          state_nxt_s = WRITE;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      WRITE: begin
        gap_cnt_nxt_s = 4'd0;
        if (GAP_CYCLES > 0) begin
          state_nxt_s = GAP;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      GAP: begin
        if (gap_cnt_r == GAP_LAST) begin
          state_nxt_s   = IDLE;
          gap_cnt_nxt_s = 4'd0;
        end else begin
          state_nxt_s   = GAP;
          gap_cnt_nxt_s = gap_cnt_r + 4'd1;
        end
      end
      default: begin
        state_nxt_s   = IDLE;
        gap_cnt_nxt_s = 4'd0;
      end
    endcase
  end

  // Next bus values: strobe only while entering WRITE, quiet bus otherwise
  always_comb begin
    cs_nxt_s    = 1'b0;
    wn_nxt_s    = 1'b1;
    addr_nxt_s  = '0;
    wdata_nxt_s = '0;
    gnt_nxt_s   = '0;
    busy_nxt_s  = (state_nxt_s != IDLE);
    if (state_nxt_s == WRITE) begin
      cs_nxt_s    = 1'b1;
      wn_nxt_s    = 1'b0;
      addr_nxt_s  = sel_addr_s;
      wdata_nxt_s = BUS_DATA_W'(sel_data_s);
      gnt_nxt_s   = pick_onehot_s;
    end else begin
      cs_nxt_s    = 1'b0;
      wn_nxt_s    = 1'b1;
      addr_nxt_s  = '0;
      wdata_nxt_s = '0;
      gnt_nxt_s   = '0;
    end
  end

  // Registered bus and handshake outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      chipselect <= 1'b0;
      write_n    <= 1'b1;
      address    <= '0;
      writedata  <= '0;
      gnt        <= '0;
      busy       <= 1'b0;
    end else begin
      chipselect <= cs_nxt_s;
      write_n    <= wn_nxt_s;
      address    <= addr_nxt_s;
      writedata  <= wdata_nxt_s;
      gnt        <= gnt_nxt_s;
      busy       <= busy_nxt_s;
    end
  end

endmodule : snake_pio_write_arbiter

// File: tb/tb_snake_pio_write_arbiter.sv
// Directed self-checking bench for snake_pio_write_arbiter.
// Instance a uses GAP_CYCLES=2, instance b uses GAP_CYCLES=0.
module tb_snake_pio_write_arbiter;

  localparam int N  = 4;
  localparam int DW = 31;
  localparam int AW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_a, rst_b;
  logic [N-1:0]    req_a, req_b;
  logic [N*AW-1:0] addr_a, addr_b;
  logic [N*DW-1:0] data_a, data_b;
  logic [N-1:0]    gnt_a, gnt_b;
  logic            busy_a, busy_b;
  logic [AW-1:0]   address_a, address_b;
  logic            cs_a, cs_b;
  logic            wn_a, wn_b;
  logic [31:0]     wd_a, wd_b;

  int n_checks = 0;
  int n_fail   = 0;

  snake_pio_write_arbiter #(.NUM_REQ(N), .DATA_W(DW), .ADDR_W(AW), .GAP_CYCLES(2)) u_dut_a (
    .clk(clk), .reset(rst_a), .req(req_a), .req_addr(addr_a), .req_data(data_a),
    .gnt(gnt_a), .busy(busy_a), .address(address_a), .chipselect(cs_a),
    .write_n(wn_a), .writedata(wd_a)
  );

  snake_pio_write_arbiter #(.NUM_REQ(N), .DATA_W(DW), .ADDR_W(AW), .GAP_CYCLES(0)) u_dut_b (
    .clk(clk), .reset(rst_b), .req(req_b), .req_addr(addr_b), .req_data(data_b),
    .gnt(gnt_b), .busy(busy_b), .address(address_b), .chipselect(cs_b),
    .write_n(wn_b), .writedata(wd_b)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_a(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    addr_a[i*AW +: AW] = a;
    data_a[i*DW +: DW] = d;
  endtask

  task automatic check_quiet_a(input string tag);
    check_eq({tag, "_cs"},    32'(cs_a),      32'd0);
    check_eq({tag, "_wn"},    32'(wn_a),      32'd1);
    check_eq({tag, "_addr"},  32'(address_a), 32'd0);
    check_eq({tag, "_wdata"}, wd_a,           32'd0);
    check_eq({tag, "_gnt"},   32'(gnt_a),     32'd0);
  endtask

  task automatic check_strobe_a(input string tag, input int w,
                                input logic [AW-1:0] a, input logic [31:0] d);
    logic [N-1:0] g;
    g = 4'b0001 << w;
    check_eq({tag, "_cs"},    32'(cs_a),      32'd1);
    check_eq({tag, "_wn"},    32'(wn_a),      32'd0);
    check_eq({tag, "_addr"},  32'(address_a), 32'(a));
    check_eq({tag, "_wdata"}, wd_a,           d);
    check_eq({tag, "_gnt"},   32'(gnt_a),     32'(g));
    check_eq({tag, "_busy"},  32'(busy_a),    32'd1);
  endtask

  initial begin
    logic prev_low;
    logic exp_strobe;
    int   w;

    rst_a = 1'b1; rst_b = 1'b1;
    req_a = '0;   req_b = '0;
    addr_a = '0;  addr_b = '0;
    data_a = '0;  data_b = '0;
    tick();
    tick();

    // Reset values
    check_quiet_a("rst");
    check_eq("rst_busy", 32'(busy_a), 32'd0);
    rst_a = 1'b0;
    tick();
    check_eq("idle_noreq_busy", 32'(busy_a), 32'd0);
    check_eq("idle_noreq_cs",   32'(cs_a),   32'd0);

    // Single request from requester 1, one-cycle req pulse
    set_a(1, 2'd0, 31'h0000_0123);
    req_a = 4'b0010;
    tick();
    check_strobe_a("t1_write", 1, 2'd0, 32'h0000_0123);
    req_a = 4'b0000;
    tick();
    check_quiet_a("t1_gap1");
    check_eq("t1_gap1_busy", 32'(busy_a), 32'd1);
    tick();
    check_eq("t1_gap2_cs",   32'(cs_a),   32'd0);
    check_eq("t1_gap2_busy", 32'(busy_a), 32'd1);
    tick();
    check_eq("t1_idle_busy", 32'(busy_a), 32'd0);

    // All four requesters held high from reset release
    for (int i = 0; i < N; i++) set_a(i, 2'(i), 31'(32'h100 + 32'(i)));
    rst_a = 1'b1;
    req_a = 4'b1111;
    tick();
    check_eq("t2_in_reset_cs", 32'(cs_a), 32'd0);
    rst_a = 1'b0;
    for (int k = 0; k < 5; k++) begin
      w = k % N;
      tick();
      check_strobe_a("t2_write", w, 2'(w), 32'h100 + 32'(w));
      for (int j = 0; j < 3; j++) begin
        tick();
        check_eq("t2_spacing_cs", 32'(cs_a), 32'd0);
      end
    end

    // Fairness: 2 served first, then with 1 and 3 waiting, 3 goes before 1
    rst_a = 1'b1;
    req_a = 4'b0100;
    tick();
    rst_a = 1'b0;
    tick();
    check_strobe_a("t3_first", 2, 2'd2, 32'h102);
    req_a = 4'b1010;
    tick();
    tick();
    tick();
    check_eq("t3_idle_busy", 32'(busy_a), 32'd0);
    tick();
    check_strobe_a("t3_second", 3, 2'd3, 32'h103);
    tick();
    tick();
    tick();
    tick();
    check_strobe_a("t3_third", 1, 2'd1, 32'h101);
    req_a = 4'b0000;
    tick();
    tick();
    tick();
    check_eq("t3_done_busy", 32'(busy_a), 32'd0);

    // Data masking: full 31-bit payload, bit 31 of the bus stays zero
    set_a(0, 2'd3, 31'h7FFF_FFFF);
    req_a = 4'b0001;
    tick();
    check_strobe_a("t5_mask", 0, 2'd3, 32'h7FFF_FFFF);
    check_eq("t5_bit31", 32'(wd_a[31]), 32'd0);
    req_a = 4'b0000;
    tick();
    tick();
    tick();

    // Reset mid-WRITE restores the pointer: requester 0 beats 3 afterwards
    req_a = 4'b0001;
    tick();
    check_strobe_a("t6_pre", 0, 2'd3, 32'h7FFF_FFFF);
    rst_a = 1'b1;
    req_a = 4'b1001;
    tick();
    check_quiet_a("t6_reset");
    check_eq("t6_reset_busy", 32'(busy_a), 32'd0);
    rst_a = 1'b0;
    tick();
    check_strobe_a("t6_after", 0, 2'd3, 32'h7FFF_FFFF);
    req_a = 4'b0000;

    // GAP_CYCLES=0 with requester 0 held: a strobe every second cycle
    addr_b[0 +: AW] = 2'd1;
    data_b[0 +: DW] = 31'h55;
    req_b = 4'b0001;
    tick();
    check_eq("t4_reset_wn", 32'(wn_b), 32'd1);
    rst_b = 1'b0;
    prev_low = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      exp_strobe = (i % 2) == 1;
      check_eq("t4_wn",   32'(wn_b),   32'(!exp_strobe));
      check_eq("t4_cs",   32'(cs_b),   32'(exp_strobe));
      check_eq("t4_busy", 32'(busy_b), 32'(exp_strobe));
      check_eq("t4_no_b2b", 32'(prev_low && (wn_b == 1'b0)), 32'd0);
      if (exp_strobe) begin
        check_eq("t4_wdata", wd_b, 32'h55);
        check_eq("t4_gnt",   32'(gnt_b), 32'd1);
        check_eq("t4_addr",  32'(address_b), 32'd1);
      end
      prev_low = (wn_b == 1'b0);
    end
    req_b = 4'b0000;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_snake_pio_write_arbiter
